wav_dfi_phy_responder: RTL and testbench
========================================

Name: wav_dfi_phy_responder

Overview:
- PHY-side DFI handshake responder: the counterpart to the MC-side DFI driver in the DFI agent.
- Answers the MC-initiated low-power handshakes (lp_ctrl, lp_data) and the controller-update handshake (ctrlupd).
- Initiates PHY-update requests (phyupd) on an internal trigger and manages their handshake, including timeout.
- Sits in the DFI verification environment as a reactive PHY model behind wav_DFI_if, and is reusable as a stub in the PHY top.

Parameters:
LP_ACK_DLY, 2, cycles from lp_*_req sampled high to lp_*_ack assertion (1..15)
TLP_RESP, 8, lp request abort window; LP_ACK_DLY < TLP_RESP is required
CTRLUPD_ACK_DLY, 1, cycles from ctrlupd_req sampled high to ack (1..15)
TPHYUPD_RESP, 16, max cycles phyupd_req waits for phyupd_ack (2..255)
PHYUPD_LEN, 4, cycles phyupd_req stays high after ack is seen (1..255)

Ports:
clock  in  1  DFI clock
reset  in  1  synchronous, active-high reset
init_start  in  1  DFI init in progress; blocks new handshakes
lp_ctrl_req  in  1  MC low-power control request
lp_ctrl_wakeup  in  6  wakeup code for lp_ctrl
lp_ctrl_ack  out  1  low-power control acknowledge
lp_data_req  in  1  MC low-power data request
lp_data_wakeup  in  6  wakeup code for lp_data
lp_data_ack  out  1  low-power data acknowledge
lp_ctrl_wakeup_lat  out  6  wakeup captured at lp_ctrl_ack assertion
lp_data_wakeup_lat  out  6  wakeup captured at lp_data_ack assertion
ctrlupd_req  in  1  MC update request
ctrlupd_ack  out  1  update acknowledge
phyupd_start  in  1  one-cycle trigger to start a PHY update
phyupd_type_in  in  2  update type captured on phyupd_start
phyupd_req  out  1  PHY update request
phyupd_type  out  2  registered update type
phyupd_ack  in  1  MC acknowledge of the PHY update
phyupd_timeout  out  1  one-cycle pulse when no ack arrives within TPHYUPD_RESP
busy  out  1  any FSM not in IDLE

Behaviour:
- Reset: every output is 0 at the first edge with reset=1; all FSMs go to IDLE and all counters clear. Reset mid-handshake behaves the same: acks and req drop immediately after that edge.
- LP FSM: two identical instances, one for ctrl and one for data. States IDLE, WAIT, ACK, REL.
  - IDLE->WAIT when req=1 and init_start=0. The counter loads 1.
  - WAIT: counter increments each cycle. req=0 returns to IDLE with no ack (request aborted). When counter==LP_ACK_DLY, go to ACK.
  - ACK: ack=1 and wakeup_lat=wakeup, both registered (ack is first visible LP_ACK_DLY+1 edges after req is sampled). While in ACK, wakeup_lat follows wakeup every cycle.
  - ACK->REL when req is sampled 0. In REL, ack=0, then return to IDLE the next cycle. A req high in REL is ignored until IDLE.
- CTRLUPD FSM: states IDLE, WAIT, ACK.
  - IDLE->WAIT when ctrlupd_req=1, init_start=0, and the phyupd FSM is IDLE. Otherwise the request is held off until those conditions hold.
  - WAIT counts to CTRLUPD_ACK_DLY, then goes to ACK. req=0 during WAIT returns to IDLE.
  - ctrlupd_ack = (state==ACK) & ctrlupd_req, combinational AND, so ack never exceeds req. req=0 in ACK returns to IDLE.
- PHYUPD FSM: states IDLE, REQ, HOLD, DROP.
  - IDLE->REQ on phyupd_start=1 when ctrlupd is IDLE and init_start=0. A start in any other case is dropped, with no queueing. phyupd_type latches phyupd_type_in and the counter clears.
  - REQ: phyupd_req=1. If phyupd_ack=1, go to HOLD with the counter cleared. Otherwise, when counter==TPHYUPD_RESP-1, pulse phyupd_timeout, deassert req, and return to IDLE.
  - HOLD: req stays 1 for PHYUPD_LEN cycles, then goes to DROP with req=0.
  - DROP: wait for phyupd_ack=0, then go to IDLE. phyupd_start is ignored until IDLE.
- Simultaneous events:
  - ctrlupd_req and phyupd_start in the same IDLE cycle: ctrlupd wins and phyupd_start is dropped.
  - lp_ctrl and lp_data are independent and may both be in ACK.
- Counters saturate and never wrap. Parameter legality is checked with an elaboration-time assertion.

Test Plan:
- lp_ctrl_req=1 held with wakeup=6'h05, LP_ACK_DLY=2 -> ack=1 three edges after req is first sampled, wakeup_lat=5. Drop req -> ack=0 one edge later.
- lp_data_req high for 1 cycle only -> no ack ever, FSM back in IDLE, busy=0 after 2 cycles.
- ctrlupd_req=1 with CTRLUPD_ACK_DLY=1 -> ack rises 2 edges later. Drop req -> ack=0 in the same cycle (combinational).
- phyupd_start with type=2'b10, MC acks after 3 cycles -> req high for 3+PHYUPD_LEN cycles, type=2 throughout. req falls and the FSM waits for ack=0 before IDLE.
- phyupd_start with phyupd_ack tied 0, TPHYUPD_RESP=16 -> req high exactly 16 cycles, then phyupd_timeout pulses once and req=0.
- Reset asserted while lp_ctrl_ack=1 and phyupd_req=1 -> all outputs 0 after the next edge. init_start=1 blocks new lp_ctrl_req and ctrlupd_req (no ack).

Source files
------------

// File: rtl/wav_dfi_phy_responder.sv
// PHY-side DFI handshake responder: answers lp_ctrl/lp_data and ctrlupd requests
// from the MC, and initiates PHY updates with an ack timeout.

module wav_dfi_phy_responder_param_chk #(
   parameter int LP_ACK_DLY      = 2,
   parameter int TLP_RESP        = 8,
   parameter int CTRLUPD_ACK_DLY = 1,
   parameter int TPHYUPD_RESP    = 16,
   parameter int PHYUPD_LEN      = 4
) ();
   generate
      if ((LP_ACK_DLY < 32'sd1) || (LP_ACK_DLY > 32'sd15) || (LP_ACK_DLY >= TLP_RESP) ||
          (CTRLUPD_ACK_DLY < 32'sd1) || (CTRLUPD_ACK_DLY > 32'sd15) ||
          (TPHYUPD_RESP < 32'sd2) || (TPHYUPD_RESP > 32'sd255) ||
          (PHYUPD_LEN < 32'sd1) || (PHYUPD_LEN > 32'sd255)) begin : g_bad_params
         $error("wav_dfi_phy_responder: illegal parameter set");
      end
   endgenerate
endmodule

module wav_dfi_phy_responder_lp #(
   parameter int ACK_DLY = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       init_start,
   input  logic       req,
   input  logic [5:0] wakeup,
   output logic       ack,
   output logic [5:0] wakeup_lat,
   output logic       active_d
);
   typedef enum logic [1:0] {
      LP_IDLE = 2'd0,
      LP_WAIT = 2'd1,
      LP_ACK  = 2'd2,
      LP_REL  = 2'd3
   } lp_state_e;

   localparam logic [3:0] ACK_DLY_C = 4'(ACK_DLY);

   lp_state_e  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       ack_q, ack_d;
   logic [5:0] lat_q, lat_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         LP_IDLE: begin
            if (req && !init_start) begin
               state_d = LP_WAIT;
               cnt_d   = 4'd1;
            end else begin
               state_d = LP_IDLE;
            end
         end
         LP_WAIT: begin
            // A request dropped before the ack is an abort: no ack is ever shown.
            if (!req) begin
               state_d = LP_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt_q == ACK_DLY_C) begin
               state_d = LP_ACK;
            end else if (cnt_q != 4'hF) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         LP_ACK: begin
            if (!req) begin
               state_d = LP_REL;
            end else begin
               state_d = LP_ACK;
            end
         end
         LP_REL: begin
            state_d = LP_IDLE;
            cnt_d   = 4'd0;
         end
         default: begin
            state_d = LP_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
      ack_d = (state_d == LP_ACK);
      if (state_d == LP_ACK) begin
         lat_d = wakeup;
      end else begin
         lat_d = lat_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= LP_IDLE;
         cnt_q   <= 4'd0;
         ack_q   <= 1'b0;
         lat_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         lat_q   <= lat_d;
      end
   end

   assign ack        = ack_q;
   assign wakeup_lat = lat_q;
   assign active_d   = (state_d != LP_IDLE);
endmodule

module wav_dfi_phy_responder #(
   parameter int LP_ACK_DLY      = 2,
   parameter int TLP_RESP        = 8,
   parameter int CTRLUPD_ACK_DLY = 1,
   parameter int TPHYUPD_RESP    = 16,
   parameter int PHYUPD_LEN      = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       init_start,
   input  logic       lp_ctrl_req,
   input  logic [5:0] lp_ctrl_wakeup,
   output logic       lp_ctrl_ack,
   input  logic       lp_data_req,
   input  logic [5:0] lp_data_wakeup,
   output logic       lp_data_ack,
   output logic [5:0] lp_ctrl_wakeup_lat,
   output logic [5:0] lp_data_wakeup_lat,
   input  logic       ctrlupd_req,
   output logic       ctrlupd_ack,
   input  logic       phyupd_start,
   input  logic [1:0] phyupd_type_in,
   output logic       phyupd_req,
   output logic [1:0] phyupd_type,
   input  logic       phyupd_ack,
   output logic       phyupd_timeout,
   output logic       busy
);
   typedef enum logic [1:0] {
      CU_IDLE = 2'd0,
      CU_WAIT = 2'd1,
      CU_ACK  = 2'd2
   } cu_state_e;

   typedef enum logic [1:0] {
      PU_IDLE = 2'd0,
      PU_REQ  = 2'd1,
      PU_HOLD = 2'd2,
      PU_DROP = 2'd3
   } pu_state_e;

   localparam logic [3:0] CU_DLY_C       = 4'(CTRLUPD_ACK_DLY);
   localparam logic [7:0] PU_RESP_LAST_C = 8'(TPHYUPD_RESP - 1);
   localparam logic [7:0] PU_LEN_LAST_C  = 8'(PHYUPD_LEN - 1);

   wav_dfi_phy_responder_param_chk #(
      .LP_ACK_DLY      (LP_ACK_DLY),
      .TLP_RESP        (TLP_RESP),
      .CTRLUPD_ACK_DLY (CTRLUPD_ACK_DLY),
      .TPHYUPD_RESP    (TPHYUPD_RESP),
      .PHYUPD_LEN      (PHYUPD_LEN)
   ) u_param_chk ();

   logic lp_ctrl_active_d;
   logic lp_data_active_d;

   wav_dfi_phy_responder_lp #(.ACK_DLY(LP_ACK_DLY)) u_lp_ctrl (
      .clock      (clock),
      .reset      (reset),
      .init_start (init_start),
      .req        (lp_ctrl_req),
      .wakeup     (lp_ctrl_wakeup),
      .ack        (lp_ctrl_ack),
      .wakeup_lat (lp_ctrl_wakeup_lat),
      .active_d   (lp_ctrl_active_d)
   );

   wav_dfi_phy_responder_lp #(.ACK_DLY(LP_ACK_DLY)) u_lp_data (
      .clock      (clock),
      .reset      (reset),
      .init_start (init_start),
      .req        (lp_data_req),
      .wakeup     (lp_data_wakeup),
      .ack        (lp_data_ack),
      .wakeup_lat (lp_data_wakeup_lat),
      .active_d   (lp_data_active_d)
   );

   cu_state_e  cu_state_q, cu_state_d;
   logic [3:0] cu_cnt_q, cu_cnt_d;
   pu_state_e  pu_state_q, pu_state_d;
   logic [7:0] pu_cnt_q, pu_cnt_d;
   logic       phyupd_req_q, phyupd_req_d;
   logic [1:0] phyupd_type_q, phyupd_type_d;
   logic       phyupd_timeout_q, phyupd_timeout_d;
   logic       busy_q, busy_d;

   always_comb begin
      cu_state_d = cu_state_q;
      cu_cnt_d   = cu_cnt_q;
      case (cu_state_q)
         CU_IDLE: begin
            // Updates are mutually exclusive: a pending ctrlupd waits out a PHY update.
            if (ctrlupd_req && !init_start && (pu_state_q == PU_IDLE)) begin
               cu_state_d = CU_WAIT;
               cu_cnt_d   = 4'd1;
            end else begin
               cu_state_d = CU_IDLE;
            end
         end
         CU_WAIT: begin
            if (!ctrlupd_req) begin
               cu_state_d = CU_IDLE;
               cu_cnt_d   = 4'd0;
            end else if (cu_cnt_q == CU_DLY_C) begin
               cu_state_d = CU_ACK;
            end else if (cu_cnt_q != 4'hF) begin
               cu_cnt_d = cu_cnt_q + 4'd1;
            end else begin
               cu_cnt_d = cu_cnt_q;
            end
         end
         CU_ACK: begin
            if (!ctrlupd_req) begin
               cu_state_d = CU_IDLE;
               cu_cnt_d   = 4'd0;
            end else begin
               cu_state_d = CU_ACK;
            end
         end
         default: begin
            cu_state_d = CU_IDLE;
            cu_cnt_d   = 4'd0;
         end
      endcase

      pu_state_d       = pu_state_q;
      pu_cnt_d         = pu_cnt_q;
      phyupd_type_d    = phyupd_type_q;
      phyupd_timeout_d = 1'b0;
      case (pu_state_q)
         PU_IDLE: begin
            // A start that collides with a ctrlupd request loses and is not queued.
            if (phyupd_start && (cu_state_q == CU_IDLE) && !init_start && !ctrlupd_req) begin
               pu_state_d    = PU_REQ;
               pu_cnt_d      = 8'd0;
               phyupd_type_d = phyupd_type_in;
            end else begin
               pu_state_d = PU_IDLE;
            end
         end
         PU_REQ: begin
            if (phyupd_ack) begin
               pu_state_d = PU_HOLD;
               pu_cnt_d   = 8'd0;
            end else if (pu_cnt_q == PU_RESP_LAST_C) begin
               pu_state_d       = PU_IDLE;
               pu_cnt_d         = 8'd0;
               phyupd_timeout_d = 1'b1;
            end else if (pu_cnt_q != 8'hFF) begin
               pu_cnt_d = pu_cnt_q + 8'd1;
            end else begin
               pu_cnt_d = pu_cnt_q;
            end
         end
         PU_HOLD: begin
            if (pu_cnt_q == PU_LEN_LAST_C) begin
               pu_state_d = PU_DROP;
               pu_cnt_d   = 8'd0;
            end else if (pu_cnt_q != 8'hFF) begin
               pu_cnt_d = pu_cnt_q + 8'd1;
            end else begin
               pu_cnt_d = pu_cnt_q;
            end
         end
         PU_DROP: begin
            if (!phyupd_ack) begin
               pu_state_d = PU_IDLE;
            end else begin
               pu_state_d = PU_DROP;
            end
         end
         default: begin
            pu_state_d = PU_IDLE;
            pu_cnt_d   = 8'd0;
         end
      endcase

      phyupd_req_d = (pu_state_d == PU_REQ) || (pu_state_d == PU_HOLD);
      busy_d       = lp_ctrl_active_d || lp_data_active_d ||
                     (cu_state_d != CU_IDLE) || (pu_state_d != PU_IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cu_state_q       <= CU_IDLE;
         cu_cnt_q         <= 4'd0;
         pu_state_q       <= PU_IDLE;
         pu_cnt_q         <= 8'd0;
         phyupd_req_q     <= 1'b0;
         phyupd_type_q    <= 2'd0;
         phyupd_timeout_q <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         cu_state_q       <= cu_state_d;
         cu_cnt_q         <= cu_cnt_d;
         pu_state_q       <= pu_state_d;
         pu_cnt_q         <= pu_cnt_d;
         phyupd_req_q     <= phyupd_req_d;
         phyupd_type_q    <= phyupd_type_d;
         phyupd_timeout_q <= phyupd_timeout_d;
         busy_q           <= busy_d;
      end
   end

   // The ack is gated by the live request so it can never outlast it.
   assign ctrlupd_ack    = (cu_state_q == CU_ACK) && ctrlupd_req;
   assign phyupd_req     = phyupd_req_q;
   assign phyupd_type    = phyupd_type_q;
   assign phyupd_timeout = phyupd_timeout_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_wav_dfi_phy_responder.sv
// Directed plus randomized bench for wav_dfi_phy_responder, checked against an
// event-level reference model of the handshake timing rules.

module tb_wav_dfi_phy_responder;
   localparam int LP_ACK_DLY      = 2;
   localparam int TLP_RESP        = 8;
   localparam int CTRLUPD_ACK_DLY = 1;
   localparam int TPHYUPD_RESP    = 16;
   localparam int PHYUPD_LEN      = 4;

   logic       clock = 1'b0;
   logic       reset, init_start;
   logic       lp_ctrl_req, lp_data_req, ctrlupd_req, phyupd_start, phyupd_ack;
   logic [5:0] lp_ctrl_wakeup, lp_data_wakeup;
   logic [1:0] phyupd_type_in;
   logic       lp_ctrl_ack, lp_data_ack, ctrlupd_ack, phyupd_req, phyupd_timeout, busy;
   logic [5:0] lp_ctrl_wakeup_lat, lp_data_wakeup_lat;
   logic [1:0] phyupd_type;

   int errors = 0;
   int checks = 0;

   // Reference model state: handshake ages in cycles since acceptance.
   bit         m_lp_act[2];
   bit         m_lp_rel[2];
   int         m_lp_age[2];
   logic [5:0] m_lp_lat[2];
   bit         m_cu_act;
   int         m_cu_age;
   bit         m_pu_busy, m_pu_held, m_pu_drop, m_pu_to;
   int         m_pu_age, m_pu_hold_age;
   logic [1:0] m_pu_type;

   wav_dfi_phy_responder #(
      .LP_ACK_DLY      (LP_ACK_DLY),
      .TLP_RESP        (TLP_RESP),
      .CTRLUPD_ACK_DLY (CTRLUPD_ACK_DLY),
      .TPHYUPD_RESP    (TPHYUPD_RESP),
      .PHYUPD_LEN      (PHYUPD_LEN)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .init_start         (init_start),
      .lp_ctrl_req        (lp_ctrl_req),
      .lp_ctrl_wakeup     (lp_ctrl_wakeup),
      .lp_ctrl_ack        (lp_ctrl_ack),
      .lp_data_req        (lp_data_req),
      .lp_data_wakeup     (lp_data_wakeup),
      .lp_data_ack        (lp_data_ack),
      .lp_ctrl_wakeup_lat (lp_ctrl_wakeup_lat),
      .lp_data_wakeup_lat (lp_data_wakeup_lat),
      .ctrlupd_req        (ctrlupd_req),
      .ctrlupd_ack        (ctrlupd_ack),
      .phyupd_start       (phyupd_start),
      .phyupd_type_in     (phyupd_type_in),
      .phyupd_req         (phyupd_req),
      .phyupd_type        (phyupd_type),
      .phyupd_ack         (phyupd_ack),
      .phyupd_timeout     (phyupd_timeout),
      .busy               (busy)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit lp_ack_exp(input int i);
      return m_lp_act[i] && (m_lp_age[i] >= LP_ACK_DLY + 1);
   endfunction

   task automatic model_edge();
      bit         lreq[2];
      logic [5:0] lwk[2];
      bit         cu_idle_prev, pu_idle_prev;
      lreq[0] = lp_ctrl_req;
      lreq[1] = lp_data_req;
      lwk[0]  = lp_ctrl_wakeup;
      lwk[1]  = lp_data_wakeup;
      m_pu_to = 1'b0;
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_lp_act[i] = 1'b0; m_lp_rel[i] = 1'b0; m_lp_age[i] = 0; m_lp_lat[i] = 6'd0;
         end
         m_cu_act = 1'b0; m_cu_age = 0;
         m_pu_busy = 1'b0; m_pu_held = 1'b0; m_pu_drop = 1'b0; m_pu_type = 2'd0;
         return;
      end
      for (int i = 0; i < 2; i++) begin
         if (m_lp_rel[i]) m_lp_rel[i] = 1'b0;
         else if (!m_lp_act[i]) begin
            if (lreq[i] && !init_start) begin m_lp_act[i] = 1'b1; m_lp_age[i] = 1; end
         end else if (!lreq[i]) begin
            m_lp_rel[i] = lp_ack_exp(i);
            m_lp_act[i] = 1'b0;
         end else m_lp_age[i]++;
         if (lp_ack_exp(i)) m_lp_lat[i] = lwk[i];
      end
      cu_idle_prev = !m_cu_act;
      pu_idle_prev = !m_pu_busy;
      if (!m_cu_act) begin
         if (ctrlupd_req && !init_start && pu_idle_prev) begin m_cu_act = 1'b1; m_cu_age = 1; end
      end else if (!ctrlupd_req) m_cu_act = 1'b0;
      else m_cu_age++;
      if (!m_pu_busy) begin
         if (phyupd_start && cu_idle_prev && !init_start && !ctrlupd_req) begin
            m_pu_busy = 1'b1; m_pu_age = 1; m_pu_type = phyupd_type_in;
            m_pu_held = 1'b0; m_pu_drop = 1'b0;
         end
      end else if (m_pu_drop) begin
         if (!phyupd_ack) m_pu_busy = 1'b0;
      end else if (m_pu_held) begin
         if (m_pu_hold_age == PHYUPD_LEN) m_pu_drop = 1'b1;
         else m_pu_hold_age++;
      end else if (phyupd_ack) begin
         m_pu_held = 1'b1; m_pu_hold_age = 1;
      end else if (m_pu_age == TPHYUPD_RESP) begin
         m_pu_busy = 1'b0; m_pu_to = 1'b1;
      end else m_pu_age++;
   endtask

   task automatic check_all();
      chk("lp_ctrl_ack", lp_ctrl_ack, lp_ack_exp(0));
      chk("lp_data_ack", lp_data_ack, lp_ack_exp(1));
      chk("lp_ctrl_lat", lp_ctrl_wakeup_lat, m_lp_lat[0]);
      chk("lp_data_lat", lp_data_wakeup_lat, m_lp_lat[1]);
      chk("ctrlupd_ack", ctrlupd_ack, m_cu_act && (m_cu_age >= CTRLUPD_ACK_DLY + 1) && ctrlupd_req);
      chk("phyupd_req", phyupd_req, m_pu_busy && !m_pu_drop);
      chk("phyupd_type", phyupd_type, m_pu_type);
      chk("phyupd_timeout", phyupd_timeout, m_pu_to);
      chk("busy", busy, m_lp_act[0] || m_lp_rel[0] || m_lp_act[1] || m_lp_rel[1] ||
                        m_cu_act || m_pu_busy);
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      int req_cycles;
      int to_pulses;
      reset = 1'b1; init_start = 1'b0;
      lp_ctrl_req = 1'b0; lp_data_req = 1'b0; ctrlupd_req = 1'b0;
      phyupd_start = 1'b0; phyupd_ack = 1'b0; phyupd_type_in = 2'd0;
      lp_ctrl_wakeup = 6'd0; lp_data_wakeup = 6'd0;

      tick();
      chk("reset_outputs", {lp_ctrl_ack, lp_data_ack, lp_ctrl_wakeup_lat, lp_data_wakeup_lat,
                            ctrlupd_ack, phyupd_req, phyupd_type, phyupd_timeout, busy}, 32'd0);
      reset = 1'b0;
      tick();

      // lp_ctrl: ack on the third edge counting the sampling edge
      lp_ctrl_wakeup = 6'h05; lp_ctrl_req = 1'b1;
      tick(); chk("lp_ack_e1", lp_ctrl_ack, 1'b0);
      tick(); chk("lp_ack_e2", lp_ctrl_ack, 1'b0);
      tick(); chk("lp_ack_e3", lp_ctrl_ack, 1'b1); chk("lp_lat_5", lp_ctrl_wakeup_lat, 6'h05);
      lp_ctrl_wakeup = 6'h2A;
      tick(); chk("lp_lat_follow", lp_ctrl_wakeup_lat, 6'h2A);
      lp_ctrl_req = 1'b0;
      tick(); chk("lp_ack_drop", lp_ctrl_ack, 1'b0);
      tick();

      // lp_data aborted after one cycle
      lp_data_req = 1'b1;
      tick(); lp_data_req = 1'b0;
      tick(); chk("lp_abort_busy", busy, 1'b0);
      tick(); chk("lp_abort_ack", lp_data_ack, 1'b0);

      // ctrlupd: ack two edges later, falls with req in the same cycle
      ctrlupd_req = 1'b1;
      tick(); chk("cu_ack_e1", ctrlupd_ack, 1'b0);
      tick(); chk("cu_ack_e2", ctrlupd_ack, 1'b1);
      ctrlupd_req = 1'b0;
      #1; chk("cu_ack_comb_drop", ctrlupd_ack, 1'b0);
      tick();

      // phyupd acked after 3 cycles
      phyupd_type_in = 2'b10; phyupd_start = 1'b1;
      tick(); phyupd_start = 1'b0; phyupd_type_in = 2'b01;
      req_cycles = phyupd_req ? 1 : 0;
      tick(); req_cycles += phyupd_req ? 1 : 0;
      tick(); req_cycles += phyupd_req ? 1 : 0;
      phyupd_ack = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick(); req_cycles += phyupd_req ? 1 : 0;
         chk("pu_type_held", phyupd_type, 2'b10);
      end
      chk("pu_req_len", req_cycles, 3 + PHYUPD_LEN);
      chk("pu_drop_wait", {busy, phyupd_req}, 2'b10);
      phyupd_ack = 1'b0;
      tick(); chk("pu_idle_busy", busy, 1'b0);

      // phyupd timeout with no ack
      phyupd_start = 1'b1;
      tick(); phyupd_start = 1'b0;
      req_cycles = phyupd_req ? 1 : 0;
      to_pulses = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         req_cycles += phyupd_req ? 1 : 0;
         to_pulses += phyupd_timeout ? 1 : 0;
      end
      chk("pu_to_req_len", req_cycles, TPHYUPD_RESP);
      chk("pu_to_pulses", to_pulses, 1);

      // reset in the middle of lp_ctrl ack and phyupd request
      lp_ctrl_req = 1'b1; phyupd_start = 1'b1;
      tick(); phyupd_start = 1'b0;
      tick(); tick();
      chk("pre_rst_state", {lp_ctrl_ack, phyupd_req}, 2'b11);
      reset = 1'b1; lp_ctrl_req = 1'b0;
      tick();
      chk("mid_rst_outputs", {lp_ctrl_ack, lp_data_ack, lp_ctrl_wakeup_lat, lp_data_wakeup_lat,
                              ctrlupd_ack, phyupd_req, phyupd_type, phyupd_timeout, busy}, 32'd0);
      reset = 1'b0;
      tick();

      // init_start blocks new handshakes
      init_start = 1'b1; lp_ctrl_req = 1'b1; ctrlupd_req = 1'b1;
      for (int k = 0; k < 6; k++) tick();
      chk("init_block", {lp_ctrl_ack, ctrlupd_ack, busy}, 3'b000);
      init_start = 1'b0; lp_ctrl_req = 1'b0; ctrlupd_req = 1'b0;
      tick();

      // ctrlupd_req and phyupd_start together: ctrlupd wins
      ctrlupd_req = 1'b1; phyupd_start = 1'b1;
      tick(); phyupd_start = 1'b0;
      chk("collide_pu_dropped", phyupd_req, 1'b0);
      tick(); chk("collide_cu_ack", ctrlupd_ack, 1'b1);
      ctrlupd_req = 1'b0;
      tick(); tick();

      // randomized traffic against the model
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 99) < 15) lp_ctrl_req = ~lp_ctrl_req;
         if ($urandom_range(0, 99) < 15) lp_data_req = ~lp_data_req;
         if ($urandom_range(0, 99) < 10) ctrlupd_req = ~ctrlupd_req;
         lp_ctrl_wakeup = 6'($urandom);
         lp_data_wakeup = 6'($urandom);
         phyupd_start   = ($urandom_range(0, 99) < 10);
         phyupd_type_in = 2'($urandom);
         if (phyupd_req) begin
            if ($urandom_range(0, 99) < 20) phyupd_ack = 1'b1;
         end else if ($urandom_range(0, 99) < 40) phyupd_ack = 1'b0;
         init_start = ($urandom_range(0, 99) < 4);
         reset      = ($urandom_range(0, 199) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
